// File: rtl/conv_out_buf_ctrl_pkg.sv
// conv_buf_pkg: shared types and width helpers for the conv output buffer
// controller and its drain pipeline.
package conv_buf_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN,
      FIN
   } state_t;

   function automatic int data_width(input int img, input int ker);
      return img + ker;
   endfunction

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int aw_of(input int depth);
      return clog2_min1(depth);
   endfunction

   function automatic int mw_of(input int dim);
      return clog2_min1(dim * dim + 1);
   endfunction

endpackage

// File: rtl/conv_out_buf_ctrl_if.sv
// conv_out_buf_ctrl_if: conv-engine, tile-buffer and writer buses.
// master = controller side, slave = surrounding datapath.
interface conv_out_buf_ctrl_if #(
   parameter int DW = 16,
   parameter int AW = 4,
   parameter int MW = 10
);

   logic          conv_valid;
   logic          conv_ready;
   logic [DW-1:0] conv_data;
   logic          buf_wr_en;
   logic [AW-1:0] buf_wr_addr;
   logic [DW-1:0] buf_wr_data;
   logic          buf_rd_en;
   logic [AW-1:0] buf_rd_addr;
   logic [DW-1:0] buf_rd_data;
   logic          mem_valid;
   logic          mem_ready;
   logic [MW-1:0] mem_addr;
   logic [DW-1:0] mem_data;

   modport master (
      input  conv_valid,
      input  conv_data,
      input  buf_rd_data,
      input  mem_ready,
      output conv_ready,
      output buf_wr_en,
      output buf_wr_addr,
      output buf_wr_data,
      output buf_rd_en,
      output buf_rd_addr,
      output mem_valid,
      output mem_addr,
      output mem_data
   );

   modport slave (
      output conv_valid,
      output conv_data,
      output buf_rd_data,
      output mem_ready,
      input  conv_ready,
      input  buf_wr_en,
      input  buf_wr_addr,
      input  buf_wr_data,
      input  buf_rd_en,
      input  buf_rd_addr,
      input  mem_valid,
      input  mem_addr,
      input  mem_data
   );

endinterface

// File: rtl/conv_out_buf_ctrl_drain.sv
// conv_buf_drain: issues tile reads and holds the registered word towards
// the writer; tracks rcnt within the tile and the layer-wide out_idx.
module conv_buf_drain #(
   parameter int CW = 4,
   parameter int AW = 4,
   parameter int MW = 10
) (
   input  logic          clock,
   input  logic          rst,
   input  logic          active,
   input  logic          clr,
   input  logic [CW-1:0] fill,
   input  logic          mem_ready,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          mem_valid,
   output logic [MW-1:0] mem_addr,
   output logic          tile_end
);

   logic [CW-1:0] rcnt_q, rcnt_d;
   logic [MW-1:0] out_idx_q, out_idx_d;
   logic          mv_q, mv_d;
   logic          acc;

   always_comb begin
      acc       = mv_q & mem_ready;
      rd_en     = active && (rcnt_q < fill)
                  && (!mv_q || mem_ready);
      tile_end  = active && acc && (rcnt_q == fill);
      rcnt_d    = rcnt_q;
      out_idx_d = out_idx_q;
      mv_d      = mv_q;
      if (rd_en) begin
         rcnt_d = rcnt_q + CW'(1);
         mv_d   = 1'b1;
      end else if (acc) begin
         mv_d = 1'b0;
      end
      if (acc) out_idx_d = out_idx_q + MW'(1);
      if (tile_end) rcnt_d = '0;
      if (clr) begin
         rcnt_d    = '0;
         out_idx_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         rcnt_q    <= '0;
         out_idx_q <= '0;
         mv_q      <= 1'b0;
      end else begin
         rcnt_q    <= rcnt_d;
         out_idx_q <= out_idx_d;
         mv_q      <= mv_d;
      end
   end

   assign rd_addr   = rcnt_q[AW-1:0];
   assign mem_valid = mv_q;
   assign mem_addr  = out_idx_q;

endmodule

// File: rtl/conv_out_buf_ctrl.sv
// conv_out_buf_ctrl: tiles conv results into a buffer and drains each tile.
// Define CONV_BUF_STALL_CNT_EN to add the stall_cycles output.
module conv_out_buf_ctrl
   import conv_buf_pkg::*;
#(
   parameter int IMAGE_PIXEL_WIDTH  = 8,
   parameter int KERNEL_PIXEL_WIDTH = 8,
   parameter int FIFO_DEPTH         = 9,
   parameter int OUT_DIM            = 26,
   localparam int DW    = data_width(IMAGE_PIXEL_WIDTH,
                                     KERNEL_PIXEL_WIDTH),
   localparam int AW    = aw_of(FIFO_DEPTH),
   localparam int TOTAL = OUT_DIM * OUT_DIM,
   localparam int MW    = mw_of(OUT_DIM)
) (
   input  logic          clock,
   input  logic          rst,
   input  logic          start,
   input  logic          flush,
   conv_out_buf_ctrl_if.master bus,
   output logic [MW-1:0] tile_count,
   output logic          busy,
`ifdef CONV_BUF_STALL_CNT_EN
   output logic          done,
   output logic [31:0]   stall_cycles
`else
   output logic          done
`endif
);

   // fill level can reach FIFO_DEPTH, one more than the address range
   localparam int CW = clog2_min1(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] LAST_W = CW'(FIFO_DEPTH - 1);
   localparam logic [MW-1:0] TOT    = MW'(TOTAL);
   localparam logic [MW-1:0] TOT_M1 = MW'(TOTAL - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic [CW-1:0] fill_q, fill_d;
   logic [MW-1:0] wr_total_q, wr_total_d;
   logic [MW-1:0] tile_q, tile_d;
   logic          flush_tk_q, flush_tk_d;
   logic          conv_ready;
   logic          wr;
   logic          layer_clr;
   logic          tile_end;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          mem_valid;
   logic [MW-1:0] mem_addr;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      fill_d     = fill_q;
      wr_total_d = wr_total_q;
      tile_d     = tile_q;
      flush_tk_d = flush_tk_q;
      conv_ready = 1'b0;
      wr         = 1'b0;
      layer_clr  = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = FILL;
               wcnt_d     = '0;
               fill_d     = '0;
               wr_total_d = '0;
               tile_d     = '0;
               flush_tk_d = 1'b0;
               layer_clr  = 1'b1;
            end
         end
         FILL: begin
            conv_ready = 1'b1;
            wr         = bus.conv_valid;
            if (wr) begin
               wcnt_d = wcnt_q + CW'(1);
               if (wr_total_q != TOT)
                  wr_total_d = wr_total_q + MW'(1);
            end
            // a same-cycle write is already folded into wcnt_d
            if (flush) begin
               flush_tk_d = 1'b1;
               fill_d     = wcnt_d;
               state_d    = (wcnt_d != '0) ? DRAIN : FIN;
            end else if (wr && (wcnt_q == LAST_W
                                || wr_total_q == TOT_M1)) begin
               fill_d  = wcnt_d;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (tile_end) begin
               tile_d  = tile_q + MW'(1);
               wcnt_d  = '0;
               state_d = (mem_addr == TOT_M1 || flush_tk_q)
                         ? FIN : FILL;
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         fill_q     <= '0;
         wr_total_q <= '0;
         tile_q     <= '0;
         flush_tk_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         fill_q     <= fill_d;
         wr_total_q <= wr_total_d;
         tile_q     <= tile_d;
         flush_tk_q <= flush_tk_d;
      end
   end

   conv_buf_drain #(
      .CW (CW),
      .AW (AW),
      .MW (MW)
   ) u_drain (
      .clock     (clock),
      .rst       (rst),
      .active    (state_q == DRAIN),
      .clr       (layer_clr),
      .fill      (fill_q),
      .mem_ready (bus.mem_ready),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .tile_end  (tile_end)
   );

   assign bus.conv_ready  = conv_ready;
   assign bus.buf_wr_en   = wr;
   assign bus.buf_wr_addr = wcnt_q[AW-1:0];
   assign bus.buf_wr_data = bus.conv_data;
   assign bus.buf_rd_en   = rd_en;
   assign bus.buf_rd_addr = rd_addr;
   assign bus.mem_valid   = mem_valid;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_data    = bus.buf_rd_data;
   assign tile_count      = tile_q;
   assign busy            = (state_q != IDLE);

`ifdef CONV_BUF_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;
   logic        stall_ev;

   always_comb begin
      stall_d  = stall_q;
      stall_ev = busy
                 && ((bus.conv_valid && !conv_ready)
                     || (mem_valid && !bus.mem_ready));
      if (layer_clr)
         stall_d = '0;
      else if (stall_ev && stall_q != '1)
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_out_buf_ctrl.sv
// tb_conv_out_buf_ctrl: directed layers on a 3x3 map with 4-entry tiles,
// scoreboarded against the accepted conv stream in order.
module tb_conv_out_buf_ctrl;
   import conv_buf_pkg::*;

   localparam int FD = 4;
   localparam int OD = 3;
   localparam int DW = data_width(8, 8);
   localparam int AW = aw_of(FD);
   localparam int MW = mw_of(OD);

   logic          clock = 1'b0;
   logic          rst;
   logic          start;
   logic          flush;
   logic [MW-1:0] tile_count;
   logic          busy;
   logic          done;
`ifdef CONV_BUF_STALL_CNT_EN
   logic [31:0]   stall_cycles;
`endif

   conv_out_buf_ctrl_if #(.DW(DW), .AW(AW), .MW(MW)) bus();

   conv_out_buf_ctrl #(
      .IMAGE_PIXEL_WIDTH  (8),
      .KERNEL_PIXEL_WIDTH (8),
      .FIFO_DEPTH         (FD),
      .OUT_DIM            (OD)
   ) dut (
      .clock        (clock),
      .rst          (rst),
      .start        (start),
      .flush        (flush),
      .bus          (bus),
      .tile_count   (tile_count),
      .busy         (busy),
`ifdef CONV_BUF_STALL_CNT_EN
      .done         (done),
      .stall_cycles (stall_cycles)
`else
      .done         (done)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int src_cnt = 0;
   int src_limit = 0;
   bit tog_en = 1'b0;
   bit mr_level = 1'b1;
   int done_cnt = 0;
   int words = 0;
   int stalls = 0;
   int exp_idx = 0;
   int tile_wr = 0;
   int last_tc = 0;
   bit prev_stall = 1'b0;
   logic [MW-1:0] prev_addr;
   logic [DW-1:0] prev_data;
   logic [MW-1:0] last_addr;
   logic [DW-1:0] last_data;
   logic [DW-1:0] q[$];
   logic [DW-1:0] bmem [FD];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // tile buffer: read data registered and held until the next read
   always @(posedge clock) begin
      if (bus.buf_wr_en) bmem[bus.buf_wr_addr] <= bus.buf_wr_data;
      if (bus.buf_rd_en) bus.buf_rd_data <= bmem[bus.buf_rd_addr];
   end

   // conv engine: per-layer sequence A5_00, A5_01, ... up to src_limit
   initial begin
      bit take;
      bit restart;
      bus.conv_valid = 1'b0;
      bus.conv_data  = '0;
      forever begin
         @(negedge clock);
         take    = bus.conv_valid && bus.conv_ready && !rst;
         restart = start && !busy && !rst;
         @(posedge clock);
         #1;
         if (restart) src_cnt = 0;
         else if (take) src_cnt++;
         bus.conv_data  = {8'hA5, 8'(src_cnt)};
         bus.conv_valid = (src_cnt < src_limit);
      end
   end

   initial begin
      bus.mem_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         bus.mem_ready = tog_en ? !bus.mem_ready : mr_level;
      end
   end

   // scoreboard: writer must see the accepted conv stream, in order,
   // at consecutive global indices from 0
   initial begin
      forever begin
         @(negedge clock);
         if (rst) begin
            q.delete();
            exp_idx    = 0;
            tile_wr    = 0;
            last_tc    = 0;
            prev_stall = 1'b0;
         end else begin
            if (start && !busy) begin
               q.delete();
               exp_idx = 0;
               tile_wr = 0;
               last_tc = 0;
            end
            if (int'(tile_count) != last_tc) begin
               last_tc = int'(tile_count);
               tile_wr = 0;
            end
            if (bus.buf_wr_en) begin
               chk("wr_addr", 32'(bus.buf_wr_addr), 32'(tile_wr));
               q.push_back(bus.conv_data);
               tile_wr++;
            end
            if (prev_stall) begin
               chk("hold_valid", 32'(bus.mem_valid), 32'd1);
               chk("hold_addr", 32'(bus.mem_addr), 32'(prev_addr));
               chk("hold_data", 32'(bus.mem_data), 32'(prev_data));
            end
            if (bus.mem_valid)
               chk("ready_in_drain", 32'(bus.conv_ready), 32'd0);
            if (bus.mem_valid && bus.mem_ready) begin
               if (q.size() == 0) begin
                  chk("extra_word", 32'd1, 32'd0);
               end else begin
                  chk("mem_addr", 32'(bus.mem_addr), 32'(exp_idx));
                  chk("mem_data", 32'(bus.mem_data), 32'(q[0]));
                  void'(q.pop_front());
               end
               last_addr = bus.mem_addr;
               last_data = bus.mem_data;
               exp_idx++;
               words++;
            end
            if (bus.mem_valid && !bus.mem_ready) stalls++;
            prev_stall = bus.mem_valid && !bus.mem_ready;
            prev_addr  = bus.mem_addr;
            prev_data  = bus.mem_data;
            if (done) done_cnt++;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clock); #2; start = 1'b1;
      @(posedge clock); #2; start = 1'b0;
   endtask

   task automatic pulse_flush();
      @(posedge clock); #2; flush = 1'b1;
      @(posedge clock); #2; flush = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clock);
         if (done) seen = 1'b1;
      end
      chk({nm, "_done_seen"}, 32'(seen), 32'd1);
      @(negedge clock);
   endtask

   task automatic wait_src(input int n);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clock);
         if (src_cnt >= n) ok = 1'b1;
      end
      chk("src_wait", 32'(ok), 32'd1);
   endtask

   task automatic wait_tc(input int n);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clock);
         if (int'(tile_count) == n) ok = 1'b1;
      end
      chk("tile_wait", 32'(ok), 32'd1);
   endtask

   task automatic wait_mv();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clock);
         if (bus.mem_valid) ok = 1'b1;
      end
      chk("mv_wait", 32'(ok), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int d0;
      int w0;
      int s0;
      rst   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_conv_ready", 32'(bus.conv_ready), 32'd0);
      chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_wr_en", 32'(bus.buf_wr_en), 32'd0);
      chk("rst_rd_en", 32'(bus.buf_rd_en), 32'd0);
      chk("rst_tiles", 32'(tile_count), 32'd0);
      @(posedge clock); #2; rst = 1'b0;

      // full layer: tiles of 4, 4, 1
      src_limit = 9;
      d0 = done_cnt; w0 = words;
      pulse_start();
      wait_done("t1");
      chk("t1_tiles", 32'(tile_count), 32'd3);
      chk("t1_words", 32'(words - w0), 32'd9);
      chk("t1_dones", 32'(done_cnt - d0), 32'd1);
      chk("t1_last_addr", 32'(last_addr), 32'd8);
      chk("t1_last_data", 32'(last_data), 32'hA508);
      chk("t1_idle", 32'(busy), 32'd0);

      // writer back-pressure toggling every cycle
      tog_en = 1'b1;
      d0 = done_cnt; w0 = words; s0 = stalls;
      pulse_start();
      wait_done("t2");
      tog_en = 1'b0;
      chk("t2_tiles", 32'(tile_count), 32'd3);
      chk("t2_words", 32'(words - w0), 32'd9);
      chk("t2_dones", 32'(done_cnt - d0), 32'd1);
      chk("t2_stalled", 32'(stalls > s0), 32'd1);

      // flush after 6 results: second tile drains 2 words
      src_limit = 6;
      d0 = done_cnt; w0 = words;
      pulse_start();
      wait_src(6);
      pulse_flush();
      wait_done("t3");
      chk("t3_tiles", 32'(tile_count), 32'd2);
      chk("t3_words", 32'(words - w0), 32'd6);
      chk("t3_last_addr", 32'(last_addr), 32'd5);
      chk("t3_last_data", 32'(last_data), 32'hA505);
      chk("t3_dones", 32'(done_cnt - d0), 32'd1);

      // flush with an empty tile goes straight to done
      src_limit = 4;
      d0 = done_cnt; w0 = words;
      pulse_start();
      wait_tc(1);
      @(posedge clock); #2; flush = 1'b1;
      @(negedge clock);
      chk("t4_done_early", 32'(done), 32'd0);
      @(posedge clock); #2; flush = 1'b0;
      @(negedge clock);
      chk("t4_done_next", 32'(done), 32'd1);
      @(negedge clock);
      chk("t4_tiles", 32'(tile_count), 32'd1);
      chk("t4_words", 32'(words - w0), 32'd4);
      chk("t4_dones", 32'(done_cnt - d0), 32'd1);

      // write and flush in the same cycle at wcnt=2
      src_limit = 2;
      d0 = done_cnt; w0 = words;
      pulse_start();
      wait_src(2);
      @(posedge clock); #2; src_limit = 3;
      @(posedge clock); #2; flush = 1'b1;
      @(posedge clock); #2; flush = 1'b0;
      wait_done("t5");
      chk("t5_tiles", 32'(tile_count), 32'd1);
      chk("t5_words", 32'(words - w0), 32'd3);
      chk("t5_last_data", 32'(last_data), 32'hA502);
      chk("t5_dones", 32'(done_cnt - d0), 32'd1);

      // reset mid-drain, then a clean layer
      src_limit = 9;
      pulse_start();
      wait_mv();
      d0 = done_cnt;
      @(posedge clock); #2; rst = 1'b1;
      @(posedge clock); #2; rst = 1'b0;
      @(negedge clock);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_mem_valid", 32'(bus.mem_valid), 32'd0);
      repeat (5) @(negedge clock);
      chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
      d0 = done_cnt; w0 = words;
      pulse_start();
      wait_done("t6");
      chk("t6_tiles", 32'(tile_count), 32'd3);
      chk("t6_words", 32'(words - w0), 32'd9);
      chk("t6_last_addr", 32'(last_addr), 32'd8);

      // start during FILL is ignored
      src_limit = 2;
      d0 = done_cnt; w0 = words;
      pulse_start();
      wait_src(2);
      pulse_start();
      @(negedge clock);
      chk("t7_busy", 32'(busy), 32'd1);
      chk("t7_tiles0", 32'(tile_count), 32'd0);
      src_limit = 9;
      wait_done("t7");
      chk("t7_tiles", 32'(tile_count), 32'd3);
      chk("t7_words", 32'(words - w0), 32'd9);
      chk("t7_dones", 32'(done_cnt - d0), 32'd1);

`ifdef CONV_BUF_STALL_CNT_EN
      // exactly 5 stalled writer cycles in a one-tile layer
      src_limit = 4;
      mr_level  = 1'b0;
      repeat (2) @(posedge clock);
      pulse_start();
      wait_mv();
      repeat (3) @(negedge clock);
      @(posedge clock); #2; mr_level = 1'b1;
      wait_tc(1);
      pulse_flush();
      wait_done("t8");
      chk("t8_stall_cycles", stall_cycles, 32'd5);
      chk("t8_tiles", 32'(tile_count), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
